bcd_to_bin_seq: RTL

//  Sequential BCD-to-binary converter (reverse double-dabble): the entry-side counterpart of the

---
 rtl/bcd_to_bin_seq.sv | 98 +++++++++
 1 files changed

// File: rtl/bcd_to_bin_seq.sv
// Sequential BCD-to-binary converter (reverse double-dabble), one conversion per start/done handshake.
// Produces a binary magnitude plus sign, overflow and bad-digit flags for the operand registers.
module bcd_to_bin_seq #(
  parameter int NDIG    = 3,
  parameter int WIDTH   = 10,
  parameter int MAX_VAL = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [4*NDIG-1:0] bcd_in,
  input  logic              neg_in,
  output logic              busy,
  output logic              done,
  output logic [WIDTH-1:0]  bin_out,
  output logic              neg_out,
  output logic              ovf,
  output logic              err_digit
);

  localparam int BW = 4*NDIG;
  localparam int CW = $clog2(BW+1);
  localparam logic [CW-1:0]    LAST = CW'(BW-1);
  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAX_VAL);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] CHECK = 2'd1;
  localparam logic [1:0] SHIFT = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]      state;
  logic [BW-1:0]   bcd_reg, bin_reg;
  logic [BW-1:0]   bcd_sh, bcd_nxt, bin_nxt;
  logic            neg_reg;
  logic [CW-1:0]   cnt;
  logic [NDIG-1:0] nib_bad;
  logic [WIDTH-1:0] res;

  assign {bcd_sh, bin_nxt} = {bcd_reg, bin_reg} >> 1;
  assign res = bin_nxt[WIDTH-1:0];

  // Per-digit: flag illegal nibbles, and undo the x2 carry after each right shift.
  for (genvar g = 0; g < NDIG; g++) begin : g_dig
    assign nib_bad[g] = bcd_reg[4*g +: 4] > 4'd9;
    assign bcd_nxt[4*g +: 4] = bcd_sh[4*g+3] ? bcd_sh[4*g +: 4] - 4'd3 : bcd_sh[4*g +: 4];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      bcd_reg   <= '0;
      bin_reg   <= '0;
      neg_reg   <= 1'b0;
      cnt       <= '0;
      bin_out   <= '0;
      neg_out   <= 1'b0;
      ovf       <= 1'b0;
      err_digit <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          bcd_reg <= bcd_in;
          neg_reg <= neg_in;
          state   <= CHECK;
        end
        CHECK: if (|nib_bad) begin
          err_digit <= 1'b1;
          bin_out   <= '0;
          neg_out   <= 1'b0;
          ovf       <= 1'b0;
          state     <= DONE;
        end else begin
          bin_reg <= '0;
          cnt     <= '0;
          state   <= SHIFT;
        end
        SHIFT: begin
          bcd_reg <= bcd_nxt;
          bin_reg <= bin_nxt;
          cnt     <= cnt + 1'b1;
          // Results come straight from the final iteration so they are valid with done.
          if (cnt == LAST) begin
            bin_out   <= res;
            neg_out   <= neg_reg & (|res);
            ovf       <= res > MAXV;
            err_digit <= 1'b0;
            state     <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == CHECK) || (state == SHIFT);
  assign done = (state == DONE);

endmodule
